// File: rtl/uart_tx_fifo_ctrl_pkg.sv
// Shared UART definitions: FSM state encodings and frame constants.
// Reused by the receive side of the UART.
package uart_tx_fifo_ctrl_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_ctrl_fifo.sv
// Synchronous FIFO for the UART transmitter.
// Ports: push/din in, pop/dout out (show-ahead), count/full/empty status.
module uart_tx_fifo_ctrl_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4,
  parameter int W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Buffered UART transmitter: valid/ready byte input, FIFO, 8N1 serialiser.
// Ports: sys_clk, sys_rst, tx_data/tx_valid/tx_ready, UART_TxD, tx_busy,
// fifo_count. Define UART_TX_PARITY_EN for 8E1 frames.
module uart_tx_fifo_ctrl
  import uart_tx_fifo_ctrl_pkg::*;
#(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             UART_TxD,
  output logic             tx_busy,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(UART_DATA_BITS - 1);

  tx_state_e     state_q;
  tx_state_e     state_d;
  logic [BW-1:0] baud_q;
  logic [BW-1:0] baud_d;
  logic [IW-1:0] bit_q;
  logic [IW-1:0] bit_d;
  logic [7:0]    sh_q;
  logic [7:0]    sh_d;
  logic          txd_d;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_dout;
  logic          full;
  logic          empty;
  logic          bit_end;

  uart_tx_fifo_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W),
    .W     (8)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push),
    .din   (tx_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  // Both status outputs come straight from flops (count, state).
  assign tx_ready = !full;
  assign push     = tx_valid && tx_ready;
  assign tx_busy  = (state_q != ST_IDLE) || !empty;
  assign bit_end  = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    if (state_q != ST_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BW'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = fifo_dout;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + IW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Chain straight into the next frame when data is waiting.
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = fifo_dout;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level is registered from the next state so it changes with it.
  always_comb begin
    txd_d = UART_IDLE_LEVEL;
    unique case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = sh_d[bit_d];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = ^sh_d;
`endif
      default:  txd_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      UART_TxD <= UART_IDLE_LEVEL;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      UART_TxD <= txd_d;
    end
  end

endmodule
